ram_port_arbiter: RTL
=====================

# ram_port_arbiter

Two-requester arbiter and sequencer for the single-port 64-bit byte-writable block RAM (65536 × 64-bit words, read/write on the falling clock edge). It accepts an instruction-fetch requester (read-only) and a data requester (read/write with byte strobes). It serialises their accesses onto the one RAM port with round-robin priority, and returns registered responses. It sits between the core's fetch/LSU bus adapters and the RAM instance.

## Interface
- `RAM_AW`, 16: RAM word-address width; requester byte addresses are `RAM_AW+3` bits.
- `clk` in 1: single clock; RAM is driven from this clock.
- `rst` in 1: synchronous, active-high reset.
- `i_req` in 1: fetch request.
- `i_addr` in RAM_AW+3: fetch byte address; bits [2:0] are ignored.
- `i_ready` out 1: fetch request accepted this cycle.
- `i_rvalid` out 1: one-cycle pulse, `i_rdata` valid.
- `i_rdata` out 64: fetched word.
- `d_req` in 1: data request.
- `d_we` in 1: 1 = write, 0 = read.
- `d_addr` in RAM_AW+3: data byte address; bits [2:0] are ignored.
- `d_wdata` in 64: write data.
- `d_wstrb` in 8: byte enables; bit k covers `d_wdata[8k+7:8k]`.
- `d_ready` out 1: data request accepted this cycle.
- `d_rvalid` out 1: one-cycle pulse; read data or write acknowledge.
- `d_rdata` out 64: read word, or the written `d_wdata` for a write.
- `ram_addr` out RAM_AW: RAM word address, registered.
- `ram_din` out 64: RAM write data, registered.
- `ram_wen` out 8: RAM byte write enables, registered.
- `ram_dout` in 64: RAM output; valid at the rising edge that ends the cycle in which `ram_addr` is presented.

## Operation
- FSM with three states: IDLE, ACCESS, RESP. A `last` flag records the last granted requester (I or D).
- **Arbitration** happens in IDLE and in RESP.
  - One request pending: grant it.
  - Both pending: grant the requester that was not granted last.
  - Granted requester gets its ready = 1 combinationally in that cycle. The other requester's ready = 0.
  - Ready is 0 in ACCESS and whenever `rst` = 1.
- **Request rules.** A requester holds req/addr/we/wdata/wstrb stable until its ready = 1. It may drop or change them after the accepting edge.
- **On grant**, at the rising edge:
  - `ram_addr` ← addr[RAM_AW+2:3].
  - `ram_din` ← `d_wdata` (data requester) or 0 (fetch).
  - `ram_wen` ← (d_we ? d_wstrb : 0) for the data requester, or 0 for fetch.
  - Owner register ← granted requester; `last` ← granted requester.
  - State → ACCESS.
- **ACCESS** (exactly one cycle):
  - The RAM performs the access on the falling edge.
  - At the closing rising edge: owner's rdata register ← `ram_dout`; `ram_wen` ← 0; state → RESP.
- **Write response data.** On a write, `ram_dout` returns `ram_din`, so `d_rdata` equals the written data, including bytes whose strobe was 0.
- **Zero-strobe write.** `d_we` = 1 with `d_wstrb` = 0 writes nothing and returns the current RAM word, exactly like a read.
- **RESP:**
  - The owner's rvalid = 1 for exactly this cycle; the other rvalid = 0.
  - rdata registers hold their value until the next response to the same requester.
  - Arbitration runs as in IDLE. On a grant, go to ACCESS; otherwise go to IDLE.
- **`ram_wen` is nonzero only during ACCESS of a data write.** No RAM write can occur in any other state.
- **Reset** (rising edge with `rst` = 1):
  - State = IDLE; `last` = I, so D wins the first conflict.
  - `ram_addr`, `ram_din`, `ram_wen` = 0.
  - `i_rvalid`, `d_rvalid` = 0; `i_rdata`, `d_rdata` = 0.
  - An in-flight access is dropped with no rvalid. A write whose ACCESS cycle overlaps the `rst` cycle still completes in RAM.

## Timing
- Accept at edge E0 (ready high in the cycle before E0).
- RAM access occurs in cycle E0–E1.
- rvalid is high in cycle E1–E2; a new grant may be accepted at E2.
- Latency from accept edge to rvalid: 1 cycle.
- Sustained throughput: one access per 2 cycles.
- Under continuous dual contention, grants alternate D, I, D, I, …
- All outputs are registered except `i_ready` and `d_ready`, which are combinational from req, state and `last`.

## Test plan
- **Reset values.** Hold `rst` for 2 cycles → all outputs 0, state IDLE; `i_ready`/`d_ready` = 0 even with both req = 1.
- **Fetch read.** Preload word 0x0010 = 0x1122334455667788; `i_req` with `i_addr` = 0x00080 → `i_ready` in the request cycle, `ram_addr` = 0x0010 the next cycle, `i_rvalid` one cycle later with `i_rdata` = 0x1122334455667788, `ram_wen` = 0 throughout.
- **Partial write, then read.** Word 0x0010 as above; write `d_addr` = 0x00080, `d_wdata` = 0xAAAAAAAAAAAAAAAA, `d_wstrb` = 0x0F → `d_rvalid` with `d_rdata` = 0xAAAA…AA. A following read returns 0x11223344AAAAAAAA.
- **Contention.** Both req held 8 cycles from reset → grants D, I, D, I. rvalids alternate with a 2-cycle period; no cycle has both rvalid = 1.
- **Zero-strobe write.** `d_we` = 1, `d_wstrb` = 0 → RAM unchanged, `ram_wen` stays 0, `d_rdata` = stored word.
- **Mid-access reset.** Assert `rst` during ACCESS of a read → no rvalid follows, state IDLE. The next request completes normally.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - fetch/data requester and RAM port bundle for ram_port_arbiter
//
// Purpose: groups both requester handshakes and the RAM port into one bundle.
// Ports (signals):
//   fetch  : i_req, i_addr -> ; <- i_ready, i_rvalid, i_rdata
//   data   : d_req, d_we, d_addr, d_wdata, d_wstrb -> ; <- d_ready, d_rvalid, d_rdata
//   ram    : <- ram_addr, ram_din, ram_wen ; ram_dout ->
// Modports: slave = arbiter side, master = requesters plus RAM side.
interface ram_port_arbiter_if #(
  parameter int RAM_AW = 16
);
  logic              i_req;
  logic [RAM_AW+2:0] i_addr;
  logic              i_ready;
  logic              i_rvalid;
  logic [63:0]       i_rdata;

  logic              d_req;
  logic              d_we;
  logic [RAM_AW+2:0] d_addr;
  logic [63:0]       d_wdata;
  logic [7:0]        d_wstrb;
  logic              d_ready;
  logic              d_rvalid;
  logic [63:0]       d_rdata;

  logic [RAM_AW-1:0] ram_addr;
  logic [63:0]       ram_din;
  logic [7:0]        ram_wen;
  logic [63:0]       ram_dout;

  modport slave (
    input  i_req, i_addr,
    output i_ready, i_rvalid, i_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    output d_ready, d_rvalid, d_rdata,
    output ram_addr, ram_din, ram_wen,
    input  ram_dout
  );

  modport master (
    output i_req, i_addr,
    input  i_ready, i_rvalid, i_rdata,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  d_ready, d_rvalid, d_rdata,
    input  ram_addr, ram_din, ram_wen,
    output ram_dout
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin fetch/data arbiter for a single-port 64-bit block RAM
//
// Purpose: serialises fetch reads and data reads/writes onto one RAM port.
// Each access takes IDLE/RESP (grant) -> ACCESS (RAM cycle) -> RESP (rvalid pulse).
// Ports:
//   clk : clock, the RAM is clocked from it (RAM acts on the falling edge)
//   rst : synchronous active-high reset
//   bus : ram_port_arbiter_if.slave, requester handshakes and RAM port
module ram_port_arbiter #(
  parameter int RAM_AW = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_port_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  state_t state;
  logic   last;   // last granted requester
  logic   owner;  // requester of the access in flight

  logic arb_ok;
  logic grant_i;
  logic grant_d;

  // Arbitration is combinational so the grant is visible as ready in the
  // request cycle; on conflict the requester not granted last wins.
  assign arb_ok  = !rst && (state != ACCESS);
  assign grant_d = arb_ok && bus.d_req && (!bus.i_req || (last == REQ_I));
  assign grant_i = arb_ok && bus.i_req && (!bus.d_req || (last == REQ_D));

  assign bus.d_ready = grant_d;
  assign bus.i_ready = grant_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last         <= REQ_I;
      owner        <= REQ_I;
      bus.ram_addr <= '0;
      bus.ram_din  <= '0;
      bus.ram_wen  <= '0;
      bus.i_rvalid <= 1'b0;
      bus.d_rvalid <= 1'b0;
      bus.i_rdata  <= '0;
      bus.d_rdata  <= '0;
    end else begin
      bus.i_rvalid <= 1'b0;
      bus.d_rvalid <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (grant_d) begin
            bus.ram_addr <= bus.d_addr[RAM_AW+2:3];
            bus.ram_din  <= bus.d_wdata;
            bus.ram_wen  <= bus.d_we ? bus.d_wstrb : 8'h00;
            owner        <= REQ_D;
            last         <= REQ_D;
            state        <= ACCESS;
          end else if (grant_i) begin
            bus.ram_addr <= bus.i_addr[RAM_AW+2:3];
            bus.ram_din  <= '0;
            bus.ram_wen  <= 8'h00;
            owner        <= REQ_I;
            last         <= REQ_I;
            state        <= ACCESS;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          // RAM has acted on the falling edge; capture its output and
          // close the write window so no later cycle can write.
          bus.ram_wen <= 8'h00;
          if (owner == REQ_D) begin
            bus.d_rdata  <= bus.ram_dout;
            bus.d_rvalid <= 1'b1;
          end else begin
            bus.i_rdata  <= bus.ram_dout;
            bus.i_rvalid <= 1'b1;
          end
          state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
